// File: rtl/bus_arb_mux_if.sv
// Channel-side inputs and registered output slot of bus_arb_mux, bundled as one interface.
// The slave modport is the arbiter; the master modport is whoever drives the channels.
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

interface bus_arb_mux_if #(
    parameter int unsigned SIGNAL_WIDTH   = `REG_WIDTH,
    parameter int unsigned CHANNELS       = 16,
    parameter int unsigned SELECTOR_WIDTH = 4
);
    logic [CHANNELS*SIGNAL_WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]              req;
    logic [CHANNELS-1:0]              lock;
    logic [SELECTOR_WIDTH-1:0]        selector;
    logic                             out_ready;
    logic [SIGNAL_WIDTH-1:0]          out_data;
    logic                             out_valid;
    logic [SELECTOR_WIDTH-1:0]        out_ch;
    logic [CHANNELS-1:0]              grant;

    modport master (
        output in_data, req, lock, selector, out_ready,
        input  out_data, out_valid, out_ch, grant
    );

    modport slave (
        input  in_data, req, lock, selector, out_ready,
        output out_data, out_valid, out_ch, grant
    );
endinterface

// File: rtl/bus_arb_mux.sv
// Channel arbiter/mux feeding a single registered output slot.
// MODE 0 picks the channel named by selector; MODE 1 round-robins with per-channel burst lock.
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module bus_arb_mux #(
    parameter int unsigned SIGNAL_WIDTH   = `REG_WIDTH,
    parameter int unsigned CHANNELS       = 16,
    parameter int unsigned SELECTOR_WIDTH = 4,
    parameter int unsigned MODE           = 0
) (
    input logic          clk,
    input logic          rst_n,
    bus_arb_mux_if.slave bus
);
    localparam int unsigned SumWidth = SELECTOR_WIDTH + 2;
    localparam logic [SumWidth-1:0] ChanSum = SumWidth'(CHANNELS);

    logic                      out_valid_q;
    logic [SIGNAL_WIDTH-1:0]   out_data_q;
    logic [SELECTOR_WIDTH-1:0] out_ch_q;
    logic [CHANNELS-1:0]       grant_q;
    logic [SELECTOR_WIDTH-1:0] rr_ptr_q;
    logic                      granted_q;

    logic                      fixed_hit;
    logic                      rr_hit;
    logic                      lock_hit;
    logic                      req_at_ptr;
    logic                      lock_at_ptr;
    logic                      win_valid;
    logic                      slot_free;
    logic                      capture;
    logic [SumWidth-1:0]       rot_amt;
    logic [2*CHANNELS-1:0]     req_rot;
    logic [SumWidth-1:0]       rr_sum;
    logic [SELECTOR_WIDTH-1:0] rr_idx;
    logic [SELECTOR_WIDTH-1:0] win_idx;
    logic [SIGNAL_WIDTH-1:0]   win_data;
    logic [CHANNELS-1:0]       win_onehot;

    always_comb begin
        fixed_hit   = 1'b0;
        req_at_ptr  = 1'b0;
        lock_at_ptr = 1'b0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (SELECTOR_WIDTH'(k) == bus.selector && bus.req[k]) begin
                fixed_hit = 1'b1;
            end
            if (SELECTOR_WIDTH'(k) == rr_ptr_q) begin
                req_at_ptr  = bus.req[k];
                lock_at_ptr = bus.lock[k];
            end
        end
    end

    // Rotate so bit j of req_rot is channel rr_ptr+1+j; the lowest set bit wins.
    always_comb begin
        rot_amt = SumWidth'(rr_ptr_q) + SumWidth'(1);
        req_rot = {bus.req, bus.req} >> rot_amt;
        rr_hit  = 1'b0;
        rr_sum  = '0;
        for (int unsigned j = 0; j < CHANNELS; j++) begin
            if (!rr_hit && req_rot[j]) begin
                rr_hit = 1'b1;
                rr_sum = rot_amt + SumWidth'(j);
            end
        end
        if (rr_sum >= ChanSum) begin
            rr_sum = rr_sum - ChanSum;
        end
        rr_idx = rr_sum[SELECTOR_WIDTH-1:0];
    end

    always_comb begin
        // Lock only holds a channel that actually won since reset.
        lock_hit = granted_q && req_at_ptr && lock_at_ptr;
        if (MODE == 1) begin
            win_valid = lock_hit || rr_hit;
            win_idx   = lock_hit ? rr_ptr_q : rr_idx;
        end else begin
            win_valid = fixed_hit;
            win_idx   = bus.selector;
        end
        win_data   = '0;
        win_onehot = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (SELECTOR_WIDTH'(k) == win_idx) begin
                win_data      = bus.in_data[k*SIGNAL_WIDTH +: SIGNAL_WIDTH];
                win_onehot[k] = 1'b1;
            end
        end
        slot_free = !out_valid_q || bus.out_ready;
        capture   = slot_free && win_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            grant_q     <= '0;
            rr_ptr_q    <= SELECTOR_WIDTH'(CHANNELS - 1);
            granted_q   <= 1'b0;
        end else begin
            grant_q <= capture ? win_onehot : '0;
            if (capture) begin
                out_valid_q <= 1'b1;
                out_data_q  <= win_data;
                out_ch_q    <= win_idx;
                rr_ptr_q    <= win_idx;
                granted_q   <= 1'b1;
            end else if (slot_free) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.grant     = grant_q;
endmodule

// File: tb/tb_bus_arb_mux.sv
// Self-checking bench for bus_arb_mux: fixed-select vector table, directed round-robin/lock/reset
// sequences, then randomized traffic on four configurations against a rule-level model.
module tb_bus_arb_mux;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bus_arb_mux_if #(.SIGNAL_WIDTH(8), .CHANNELS(16), .SELECTOR_WIDTH(4)) if0 ();
    bus_arb_mux_if #(.SIGNAL_WIDTH(8), .CHANNELS(4),  .SELECTOR_WIDTH(2)) if1 ();
    bus_arb_mux_if #(.SIGNAL_WIDTH(8), .CHANNELS(8),  .SELECTOR_WIDTH(4)) if2 ();
    bus_arb_mux_if #(.SIGNAL_WIDTH(8), .CHANNELS(5),  .SELECTOR_WIDTH(3)) if3 ();

    bus_arb_mux #(.SIGNAL_WIDTH(8), .CHANNELS(16), .SELECTOR_WIDTH(4), .MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    bus_arb_mux #(.SIGNAL_WIDTH(8), .CHANNELS(4), .SELECTOR_WIDTH(2), .MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));
    bus_arb_mux #(.SIGNAL_WIDTH(8), .CHANNELS(8), .SELECTOR_WIDTH(4), .MODE(0)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(if2));
    bus_arb_mux #(.SIGNAL_WIDTH(8), .CHANNELS(5), .SELECTOR_WIDTH(3), .MODE(1)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(if3));

    typedef struct {
        bit valid;
        int data;
        int ch;
        int gch;       // granted channel this cycle, -1 for none
        int last;      // last granted channel (CHANNELS-1 after reset)
        bit have_last; // a grant happened since reset
    } mstate_t;

    typedef struct {
        int        sel;
        bit [15:0] req;
        int        dat;
        bit        rdy;
        bit        ev;
        int        ed;
        int        ech;
        bit [15:0] eg;
    } vec_t;

    int      n_chk = 0;
    int      n_fail = 0;
    int      dat[16];
    mstate_t ms[4];
    int      cfg_mode[4] = '{0, 1, 0, 1};
    int      cfg_nch[4]  = '{16, 4, 8, 5};

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic get_out(input int j, output logic [31:0] v, output logic [31:0] d,
                           output logic [31:0] c, output logic [31:0] g);
        case (j)
            0: begin v = 32'(if0.out_valid); d = 32'(if0.out_data); c = 32'(if0.out_ch);
                     g = 32'(if0.grant); end
            1: begin v = 32'(if1.out_valid); d = 32'(if1.out_data); c = 32'(if1.out_ch);
                     g = 32'(if1.grant); end
            2: begin v = 32'(if2.out_valid); d = 32'(if2.out_data); c = 32'(if2.out_ch);
                     g = 32'(if2.grant); end
            default: begin v = 32'(if3.out_valid); d = 32'(if3.out_data); c = 32'(if3.out_ch);
                     g = 32'(if3.grant); end
        endcase
    endtask

    task automatic chk(input int j, input string nm, input int ev, input int ed, input int ec,
                       input int eg);
        logic [31:0] v, d, c, g;
        get_out(j, v, d, c, g);
        cmp($sformatf("%s u%0d out_valid", nm, j), v, 32'(ev));
        cmp($sformatf("%s u%0d out_data", nm, j), d, 32'(ed));
        cmp($sformatf("%s u%0d out_ch", nm, j), c, 32'(ec));
        cmp($sformatf("%s u%0d grant", nm, j), g, 32'(eg));
    endtask

    function automatic mstate_t model_rst(int nch);
        mstate_t s;
        s.valid = 1'b0; s.data = 0; s.ch = 0; s.gch = -1; s.last = nch - 1; s.have_last = 1'b0;
        return s;
    endfunction

    // Next output state from the arbitration rules, using the channel data in dat[].
    function automatic mstate_t model_next(mstate_t s, int j, bit rn, bit [15:0] req,
                                           bit [15:0] lock, int sel, bit rdy);
        mstate_t n;
        int nch, w;
        nch = cfg_nch[j];
        if (!rn) return model_rst(nch);
        n = s;
        n.gch = -1;
        w = -1;
        if (cfg_mode[j] == 0) begin
            if (sel < nch && req[sel]) w = sel;
        end else if (s.have_last && req[s.last] && lock[s.last]) begin
            w = s.last;
        end else begin
            for (int i = 1; i <= nch; i++) begin
                if (w < 0 && req[(s.last + i) % nch]) w = (s.last + i) % nch;
            end
        end
        if (!s.valid || rdy) begin
            if (w >= 0) begin
                n.valid = 1'b1; n.data = dat[w]; n.ch = w; n.gch = w;
                n.last = w; n.have_last = 1'b1;
            end else begin
                n.valid = 1'b0;
            end
        end
        return n;
    endfunction

    task automatic chk_model(input int j, input string nm);
        chk(j, nm, int'(ms[j].valid), ms[j].data, ms[j].ch,
            (ms[j].gch < 0) ? 0 : (1 << ms[j].gch));
    endtask

    task automatic drive(input bit rn, input bit [15:0] req, input bit [15:0] lock,
                         input int sel, input bit rdy);
        rst_n = rn;
        if0.req = req;       if0.lock = lock;       if0.selector = 4'(sel); if0.out_ready = rdy;
        if1.req = req[3:0];  if1.lock = lock[3:0];  if1.selector = 2'(sel); if1.out_ready = rdy;
        if2.req = req[7:0];  if2.lock = lock[7:0];  if2.selector = 4'(sel); if2.out_ready = rdy;
        if3.req = req[4:0];  if3.lock = lock[4:0];  if3.selector = 3'(sel); if3.out_ready = rdy;
        for (int k = 0; k < 16; k++) if0.in_data[k*8 +: 8] = 8'(dat[k]);
        for (int k = 0; k < 4; k++)  if1.in_data[k*8 +: 8] = 8'(dat[k]);
        for (int k = 0; k < 8; k++)  if2.in_data[k*8 +: 8] = 8'(dat[k]);
        for (int k = 0; k < 5; k++)  if3.in_data[k*8 +: 8] = 8'(dat[k]);
    endtask

    // One reset edge, then one idle edge with reset released.
    task automatic reset_all();
        drive(1'b0, 16'h0, 16'h0, 0, 1'b0);
        @(negedge clk);
        drive(1'b1, 16'h0, 16'h0, 0, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[$];
        int   rr_lock[$] = '{0, 0, 0, 0, 0, 4, 4, 4, 4, 0, 0};
        int   rr_exp[$]  = '{0, 1, 2, 3, 0, 1, 2, 2, 2, 3, 0};
        int   sel35[$]   = '{12, 8, 15};
        bit   prev_rn;

        for (int k = 0; k < 16; k++) dat[k] = 0;
        drive(1'b0, 16'h0, 16'h0, 0, 1'b0);
        @(negedge clk);
        drive(1'b0, 16'hFFFF, 16'hFFFF, 5, 1'b1);   // ignored while in reset
        @(negedge clk);
        for (int j = 0; j < 4; j++) chk(j, "reset", 0, 0, 0, 0);
        drive(1'b1, 16'h0, 16'h0, 0, 1'b0);
        @(negedge clk);

        // MODE 0, 16 channels; channel k carries dat + k.
        vt.push_back('{5,  16'h0020, 'hA0, 1'b1, 1'b1, 'hA5, 5,  16'h0020});
        vt.push_back('{5,  16'h0000, 'h10, 1'b1, 1'b0, 'hA5, 5,  16'h0000});
        vt.push_back('{3,  16'h0020, 'h10, 1'b1, 1'b0, 'hA5, 5,  16'h0000});
        vt.push_back('{15, 16'h8000, 'h30, 1'b1, 1'b1, 'h3F, 15, 16'h8000});
        vt.push_back('{0,  16'hFFFF, 'h40, 1'b0, 1'b1, 'h3F, 15, 16'h0000});
        vt.push_back('{0,  16'hFFFF, 'h40, 1'b1, 1'b1, 'h40, 0,  16'h0001});
        vt.push_back('{7,  16'h0080, 'h50, 1'b1, 1'b1, 'h57, 7,  16'h0080});
        vt.push_back('{7,  16'h0080, 'h60, 1'b1, 1'b1, 'h67, 7,  16'h0080});
        vt.push_back('{9,  16'h0000, 'h00, 1'b1, 1'b0, 'h67, 7,  16'h0000});
        vt.push_back('{2,  16'h0004, 'h3A, 1'b1, 1'b1, 'h3C, 2,  16'h0004});
        vt.push_back('{2,  16'h0004, 'h11, 1'b0, 1'b1, 'h3C, 2,  16'h0000});
        vt.push_back('{2,  16'h0004, 'h22, 1'b0, 1'b1, 'h3C, 2,  16'h0000});
        vt.push_back('{2,  16'h0004, 'h33, 1'b0, 1'b1, 'h3C, 2,  16'h0000});
        vt.push_back('{2,  16'h0004, 'h44, 1'b0, 1'b1, 'h3C, 2,  16'h0000});
        vt.push_back('{2,  16'h0004, 'h50, 1'b1, 1'b1, 'h52, 2,  16'h0004});
        vt.push_back('{2,  16'h0004, 'h50, 1'b0, 1'b1, 'h52, 2,  16'h0000});
        vt.push_back('{0,  16'h0000, 'h00, 1'b0, 1'b1, 'h52, 2,  16'h0000});
        vt.push_back('{0,  16'h0000, 'h00, 1'b1, 1'b0, 'h52, 2,  16'h0000});
        foreach (vt[i]) begin
            for (int k = 0; k < 16; k++) dat[k] = (vt[i].dat + k) & 255;
            drive(1'b1, vt[i].req, 16'h0, vt[i].sel, vt[i].rdy);
            @(negedge clk);
            chk(0, $sformatf("vec%0d", i), int'(vt[i].ev), vt[i].ed, vt[i].ech, int'(vt[i].eg));
        end

        // MODE 0, 8 channels: out-of-range selectors never win.
        reset_all();
        for (int k = 0; k < 16; k++) dat[k] = 'h80 + k;
        foreach (sel35[i]) begin
            drive(1'b1, 16'hFFFF, 16'h0, sel35[i], 1'b1);
            @(negedge clk);
            chk(2, $sformatf("sel%0d", sel35[i]), 0, 0, 0, 0);
        end
        drive(1'b1, 16'hFFFF, 16'h0, 3, 1'b1);
        @(negedge clk);
        chk(2, "sel3", 1, 'h83, 3, 'h08);
        drive(1'b1, 16'hFFFF, 16'h0, 12, 1'b1);
        @(negedge clk);
        chk(2, "sel12 after word", 0, 'h83, 3, 0);

        // MODE 1, 4 channels: rotation, wrap, and lock on ch2.
        reset_all();
        for (int k = 0; k < 16; k++) dat[k] = (16 * (k + 1)) & 255;
        foreach (rr_exp[i]) begin
            drive(1'b1, 16'h000F, 16'(rr_lock[i]), 0, 1'b1);
            @(negedge clk);
            chk(1, $sformatf("rr%0d", i), 1, 16 * (rr_exp[i] + 1), rr_exp[i], 1 << rr_exp[i]);
        end

        // Reset while a word is held under backpressure.
        drive(1'b1, 16'h000F, 16'h0, 0, 1'b0);
        @(negedge clk);
        chk(1, "stall", 1, 16, 0, 0);
        drive(1'b0, 16'hFFFF, 16'hFFFF, 0, 1'b0);
        @(negedge clk);
        chk(1, "rst mid", 0, 0, 0, 0);
        drive(1'b1, 16'h0, 16'h0008, 0, 1'b1);
        @(negedge clk);
        chk(1, "post rst idle", 0, 0, 0, 0);
        drive(1'b1, 16'h000F, 16'h0008, 0, 1'b1);
        @(negedge clk);
        chk(1, "post rst first", 1, 16, 0, 1);

        // Random traffic on all four instances.
        prev_rn = 1'b1;
        for (int it = 0; it < 3000; it++) begin
            bit        rn;
            bit [15:0] req;
            bit [15:0] lock;
            int        sel;
            bit        rdy;
            rn   = !(it == 0 || $urandom_range(99) == 0);
            req  = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
            if (rn && !prev_rn) req = 16'h0;
            lock = 16'($urandom) & 16'($urandom);
            sel  = int'($urandom_range(15));
            rdy  = ($urandom_range(3) != 0);
            for (int k = 0; k < 16; k++) dat[k] = int'($urandom_range(255));
            drive(rn, req, lock, sel, rdy);
            @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                ms[j] = model_next(ms[j], j, rn, req, lock, sel, rdy);
                chk_model(j, $sformatf("rand%0d", it));
            end
            prev_rn = rn;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
